// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: packet-control state encoding and
// header address constants.
package router_pkg;

    localparam int ADDR_W  = 2;
    localparam int STATE_W = 3;

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    // Picks the per-port flag addressed by a destination; the invalid
    // address has no port behind it and always reads as 0.
    function automatic logic port_flag(input logic [2:0] flags,
                                       input logic [ADDR_W-1:0] addr);
        logic r;
        r = 1'b0;
        case (addr)
            2'd0:    r = flags[0];
            2'd1:    r = flags[1];
            2'd2:    r = flags[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-control FSM for the 1x3 router: sequences header decode, payload,
// FIFO-full stall and parity phases; all strobes are Moore decodes of state.
module router_fsm
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic [ADDR_W-1:0] dest_addr,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_dest_addr;

    logic [2:0] w_fifo_empty;
    logic [2:0] w_soft_reset;
    logic       w_soft_reset_sel;
    logic       w_hdr_valid;
    logic       w_hdr_port_empty;
    logic       w_dest_port_empty;

    assign w_fifo_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign w_soft_reset = {soft_reset_2, soft_reset_1, soft_reset_0};

    // Only the timeout of the port this packet is bound for may abort it.
    assign w_soft_reset_sel  = port_flag(w_soft_reset, r_dest_addr);
    assign w_hdr_valid       = pkt_valid && (data_in != INVALID_ADDR);
    assign w_hdr_port_empty  = port_flag(w_fifo_empty, data_in);
    assign w_dest_port_empty = port_flag(w_fifo_empty, r_dest_addr);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= DECODE_ADDRESS;
            r_dest_addr <= '0;
        end else if (w_soft_reset_sel) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (w_hdr_valid) begin
                        r_dest_addr <= data_in;
                        r_state     <= w_hdr_port_empty ? LOAD_FIRST_DATA
                                                        : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: r_state <= LOAD_DATA;
                LOAD_DATA: begin
                    // A full FIFO wins over end-of-packet so the last byte is not lost.
                    if (fifo_full)
                        r_state <= FIFO_FULL_STATE;
                    else if (!pkt_valid)
                        r_state <= LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full)
                        r_state <= LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        r_state <= DECODE_ADDRESS;
                    else if (low_pkt_valid)
                        r_state <= LOAD_PARITY;
                    else
                        r_state <= LOAD_DATA;
                end
                LOAD_PARITY: r_state <= CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    r_state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (w_dest_port_empty)
                        r_state <= LOAD_FIRST_DATA;
                end
                default: r_state <= DECODE_ADDRESS;
            endcase
        end
    end

    assign dest_addr     = r_dest_addr;
    assign detect_add    = (r_state == DECODE_ADDRESS);
    assign lfd_state     = (r_state == LOAD_FIRST_DATA);
    assign ld_state      = (r_state == LOAD_DATA);
    assign laf_state     = (r_state == LOAD_AFTER_FULL);
    assign full_state    = (r_state == FIFO_FULL_STATE);
    assign write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                           (r_state == LOAD_AFTER_FULL);
    assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    assign busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed scenario tasks plus a
// randomized run against a behavioural packet-phase model.
module tb_router_fsm;

    localparam int PH_DEC  = 10;
    localparam int PH_LFD  = 11;
    localparam int PH_LD   = 12;
    localparam int PH_LP   = 13;
    localparam int PH_FULL = 14;
    localparam int PH_LAF  = 15;
    localparam int PH_WTE  = 16;
    localparam int PH_CPE  = 17;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [1:0] dest_addr;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;

    int n_checks = 0;
    int n_pass   = 0;

    int         m_ph;
    logic [1:0] m_dest;

    typedef struct {
        logic       pv;
        logic [1:0] din;
        logic       ff;
        logic [2:0] fe;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        int         ph;
        logic [1:0] dest;
    } stim_t;

    router_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .dest_addr     (dest_addr),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    wire [7:0] obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                      write_enb_reg, rst_int_reg, busy};

    // Expected strobes per phase: {detect,lfd,ld,laf,full,write_enb,rst_int,busy}
    function automatic logic [7:0] flags(input int ph);
        case (ph)
            PH_DEC:  return 8'b1000_0000;
            PH_LFD:  return 8'b0100_0001;
            PH_LD:   return 8'b0010_0100;
            PH_LAF:  return 8'b0001_0101;
            PH_FULL: return 8'b0000_1001;
            PH_LP:   return 8'b0000_0101;
            PH_CPE:  return 8'b0000_0011;
            PH_WTE:  return 8'b0000_0001;
            default: return 8'hxx;
        endcase
    endfunction

    function automatic stim_t S(input logic pv, input logic [1:0] din, input logic ff,
                                input logic [2:0] fe, input logic [2:0] sr,
                                input logic pd, input logic lpv,
                                input int ph, input logic [1:0] dest);
        stim_t s;
        s.pv = pv; s.din = din; s.ff = ff; s.fe = fe; s.sr = sr;
        s.pd = pd; s.lpv = lpv; s.ph = ph; s.dest = dest;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        pkt_valid     = s.pv;
        data_in       = s.din;
        fifo_full     = s.ff;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = s.fe;
        {soft_reset_2, soft_reset_1, soft_reset_0} = s.sr;
        parity_done   = s.pd;
        low_pkt_valid = s.lpv;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Behavioural model of the packet flow, advanced with the inputs present
    // just before the coming clock edge.
    function automatic void model_step();
        logic [2:0] sr;
        logic [2:0] fe;
        sr = {soft_reset_2, soft_reset_1, soft_reset_0};
        fe = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        if (!resetn) begin
            m_ph = PH_DEC;
            m_dest = 2'd0;
        end else if (m_dest != 2'd3 && sr[m_dest]) begin
            m_ph = PH_DEC;
        end else if (m_ph == PH_DEC) begin
            if (pkt_valid && data_in != 2'd3) begin
                m_dest = data_in;
                m_ph = fe[data_in] ? PH_LFD : PH_WTE;
            end
        end else if (m_ph == PH_LFD) m_ph = PH_LD;
        else if (m_ph == PH_LD) begin
            if (fifo_full) m_ph = PH_FULL;
            else if (!pkt_valid) m_ph = PH_LP;
        end else if (m_ph == PH_FULL) begin
            if (!fifo_full) m_ph = PH_LAF;
        end else if (m_ph == PH_LAF) begin
            m_ph = parity_done ? PH_DEC : (low_pkt_valid ? PH_LP : PH_LD);
        end else if (m_ph == PH_LP) m_ph = PH_CPE;
        else if (m_ph == PH_CPE) m_ph = fifo_full ? PH_FULL : PH_DEC;
        else if (m_ph == PH_WTE) begin
            if (fe[m_dest]) m_ph = PH_LFD;
        end
    endfunction

    task automatic test_reset;
        apply(S(0, 0, 0, 3'b000, 3'b000, 0, 0, PH_DEC, 0));
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n_checks++;
        if ({obs, dest_addr} !== {flags(PH_DEC), 2'd0}) begin
            $display("FAIL reset_state: got strobes=%b dest=%0d, expected strobes=%b dest=0",
                     obs, dest_addr, flags(PH_DEC));
        end else n_pass++;
        apply(S(1, 1, 0, 3'b010, 3'b000, 0, 0, PH_LFD, 1));
        tick();
        n_checks++;
        if ({obs, dest_addr} !== {flags(PH_LFD), 2'd1}) begin
            $display("FAIL reset_hdr: got strobes=%b dest=%0d, expected strobes=%b dest=1",
                     obs, dest_addr, flags(PH_LFD));
        end else n_pass++;
        apply(S(1, 2, 1, 3'b111, 3'b000, 1, 1, PH_DEC, 0));
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n_checks++;
        if ({obs, dest_addr} !== {flags(PH_DEC), 2'd0}) begin
            $display("FAIL reset_midpkt: got strobes=%b dest=%0d, expected strobes=%b dest=0",
                     obs, dest_addr, flags(PH_DEC));
        end else n_pass++;
    endtask

    task automatic test_normal_packet;
        stim_t q[$];
        int    rst_int_cycles = 0;
        q.push_back(S(1, 1, 0, 3'b010, 3'b000, 0, 0, PH_LFD, 1));
        q.push_back(S(1, 2, 0, 3'b010, 3'b000, 0, 0, PH_LD,  1));
        q.push_back(S(1, 0, 0, 3'b010, 3'b000, 0, 0, PH_LD,  1));
        q.push_back(S(0, 3, 0, 3'b010, 3'b000, 0, 0, PH_LP,  1));
        q.push_back(S(0, 0, 0, 3'b010, 3'b000, 0, 0, PH_CPE, 1));
        q.push_back(S(0, 0, 0, 3'b010, 3'b000, 0, 0, PH_DEC, 1));
        foreach (q[i]) begin
            apply(q[i]);
            tick();
            if (rst_int_reg === 1'b1) rst_int_cycles++;
            n_checks++;
            if ({obs, dest_addr} !== {flags(q[i].ph), q[i].dest}) begin
                $display("FAIL normal_pkt step %0d: got strobes=%b dest=%0d, expected strobes=%b dest=%0d",
                         i, obs, dest_addr, flags(q[i].ph), q[i].dest);
            end else n_pass++;
        end
        n_checks++;
        if (rst_int_cycles != 1) begin
            $display("FAIL rst_int_width: got %0d cycles, expected 1", rst_int_cycles);
        end else n_pass++;
    endtask

    task automatic test_busy_dest;
        stim_t q[$];
        for (int i = 0; i < 5; i++)
            q.push_back(S(1, 2, 0, 3'b000, 3'b000, 0, 0, PH_WTE, 2));
        q.push_back(S(1, 2, 0, 3'b100, 3'b000, 0, 0, PH_LFD, 2));
        q.push_back(S(1, 1, 0, 3'b100, 3'b000, 0, 0, PH_LD,  2));
        q.push_back(S(1, 1, 0, 3'b100, 3'b100, 0, 0, PH_DEC, 2));
        foreach (q[i]) begin
            apply(q[i]);
            tick();
            n_checks++;
            if ({obs, dest_addr} !== {flags(q[i].ph), q[i].dest}) begin
                $display("FAIL busy_dest step %0d: got strobes=%b dest=%0d, expected strobes=%b dest=%0d",
                         i, obs, dest_addr, flags(q[i].ph), q[i].dest);
            end else n_pass++;
        end
    endtask

    task automatic test_full_stall;
        stim_t q[$];
        q.push_back(S(1, 0, 0, 3'b001, 3'b000, 0, 0, PH_LFD,  0));
        q.push_back(S(1, 0, 0, 3'b001, 3'b000, 0, 0, PH_LD,   0));
        for (int i = 0; i < 4; i++)
            q.push_back(S(1, 0, 1, 3'b001, 3'b000, 0, 0, PH_FULL, 0));
        q.push_back(S(1, 0, 0, 3'b001, 3'b000, 0, 0, PH_LAF,  0));
        q.push_back(S(0, 0, 0, 3'b001, 3'b000, 0, 1, PH_LP,   0));
        q.push_back(S(0, 0, 0, 3'b001, 3'b000, 0, 0, PH_CPE,  0));
        q.push_back(S(0, 0, 1, 3'b001, 3'b000, 0, 0, PH_FULL, 0));
        q.push_back(S(0, 0, 0, 3'b001, 3'b000, 0, 0, PH_LAF,  0));
        q.push_back(S(0, 0, 0, 3'b001, 3'b000, 1, 0, PH_DEC,  0));
        q.push_back(S(1, 0, 0, 3'b001, 3'b000, 0, 0, PH_LFD,  0));
        q.push_back(S(1, 0, 0, 3'b001, 3'b000, 0, 0, PH_LD,   0));
        q.push_back(S(0, 0, 1, 3'b001, 3'b000, 0, 0, PH_FULL, 0));
        q.push_back(S(0, 0, 0, 3'b001, 3'b000, 0, 0, PH_LAF,  0));
        q.push_back(S(1, 0, 0, 3'b001, 3'b000, 0, 0, PH_LD,   0));
        q.push_back(S(0, 0, 0, 3'b001, 3'b000, 0, 0, PH_LP,   0));
        q.push_back(S(0, 0, 0, 3'b001, 3'b000, 0, 0, PH_CPE,  0));
        q.push_back(S(0, 0, 0, 3'b001, 3'b000, 0, 0, PH_DEC,  0));
        foreach (q[i]) begin
            apply(q[i]);
            tick();
            n_checks++;
            if ({obs, dest_addr} !== {flags(q[i].ph), q[i].dest}) begin
                $display("FAIL full_stall step %0d: got strobes=%b dest=%0d, expected strobes=%b dest=%0d",
                         i, obs, dest_addr, flags(q[i].ph), q[i].dest);
            end else n_pass++;
        end
    endtask

    task automatic test_soft_reset;
        stim_t q[$];
        q.push_back(S(1, 0, 0, 3'b001, 3'b000, 0, 0, PH_LFD,  0));
        q.push_back(S(1, 0, 0, 3'b001, 3'b010, 0, 0, PH_LD,   0));
        q.push_back(S(1, 0, 0, 3'b001, 3'b110, 0, 0, PH_LD,   0));
        q.push_back(S(1, 0, 0, 3'b001, 3'b001, 0, 0, PH_DEC,  0));
        q.push_back(S(1, 0, 0, 3'b001, 3'b000, 0, 0, PH_LFD,  0));
        q.push_back(S(1, 0, 0, 3'b001, 3'b000, 0, 0, PH_LD,   0));
        q.push_back(S(1, 0, 1, 3'b001, 3'b000, 0, 0, PH_FULL, 0));
        q.push_back(S(1, 0, 1, 3'b001, 3'b001, 0, 0, PH_DEC,  0));
        q.push_back(S(1, 1, 0, 3'b010, 3'b001, 0, 0, PH_DEC,  0));
        foreach (q[i]) begin
            apply(q[i]);
            tick();
            n_checks++;
            if ({obs, dest_addr} !== {flags(q[i].ph), q[i].dest}) begin
                $display("FAIL soft_reset step %0d: got strobes=%b dest=%0d, expected strobes=%b dest=%0d",
                         i, obs, dest_addr, flags(q[i].ph), q[i].dest);
            end else n_pass++;
        end
    endtask

    task automatic test_invalid_header;
        stim_t q[$];
        q.push_back(S(1, 3, 0, 3'b111, 3'b000, 0, 0, PH_DEC, 0));
        q.push_back(S(1, 3, 0, 3'b111, 3'b000, 0, 0, PH_DEC, 0));
        q.push_back(S(0, 1, 0, 3'b111, 3'b000, 0, 0, PH_DEC, 0));
        q.push_back(S(1, 2, 0, 3'b111, 3'b000, 0, 0, PH_LFD, 2));
        q.push_back(S(1, 2, 0, 3'b111, 3'b100, 0, 0, PH_DEC, 2));
        q.push_back(S(1, 3, 0, 3'b111, 3'b000, 0, 0, PH_DEC, 2));
        foreach (q[i]) begin
            apply(q[i]);
            tick();
            n_checks++;
            if ({obs, dest_addr} !== {flags(q[i].ph), q[i].dest}) begin
                $display("FAIL invalid_hdr step %0d: got strobes=%b dest=%0d, expected strobes=%b dest=%0d",
                         i, obs, dest_addr, flags(q[i].ph), q[i].dest);
            end else n_pass++;
        end
    endtask

    task automatic test_random;
        int errs = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            resetn        = (cyc == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            fifo_empty_0  = ($urandom_range(0, 1) == 0);
            fifo_empty_1  = ($urandom_range(0, 1) == 0);
            fifo_empty_2  = ($urandom_range(0, 1) == 0);
            soft_reset_0  = ($urandom_range(0, 29) == 0);
            soft_reset_1  = ($urandom_range(0, 29) == 0);
            soft_reset_2  = ($urandom_range(0, 29) == 0);
            parity_done   = ($urandom_range(0, 4) == 0);
            low_pkt_valid = ($urandom_range(0, 4) == 0);
            model_step();
            tick();
            n_checks++;
            if ({obs, dest_addr} !== {flags(m_ph), m_dest}) begin
                if (errs < 10)
                    $display("FAIL random cycle %0d: got strobes=%b dest=%0d, expected strobes=%b dest=%0d",
                             cyc, obs, dest_addr, flags(m_ph), m_dest);
                errs++;
            end else n_pass++;
        end
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b1;
        apply(S(0, 0, 0, 3'b000, 3'b000, 0, 0, PH_DEC, 0));
        tick();
        test_reset();
        test_normal_packet();
        test_busy_dest();
        test_full_stall();
        test_soft_reset();
        test_invalid_header();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
